fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 run  in  1  level; start or continue fetching while high.
REQ-005 mem_rdy  in  1  memory read data valid this cycle.
REQ-006 mem_data  in  8  instruction byte from memory.
REQ-007 dec_ack  in  1  decoder accepted the presented instruction.
REQ-008 jmp  in  1  qualified by dec_ack; redirect fetch to jmp_addr.
REQ-009 jmp_addr  in  16  jump target.
REQ-010 mem_rd  out  1  memory read strobe.
REQ-011 pc_oe  out  1  drive PC onto address bus.
REQ-012 pc_ini  out  1  one-cycle PC increment pulse.
REQ-013 pc_lrc  out  1  one-cycle PC load pulse.
REQ-014 pc_ld  out  16  load value for PC, valid when pc_lrc=1.
REQ-015 ir  out  8  instruction register.
REQ-016 ir_vld  out  1  ir holds an unconsumed instruction.
REQ-017 is  out  3  current state encoding.
REQ-018 err  out  1  sticky memory-timeout flag (tied 0 without macro).

Function
REQ-019 States, is encoding: IDLE=0, ADDR=1, WAIT=2, LATCH=3, DISP=4, LOAD=5; 6-7 unused, SHALL go to IDLE.
REQ-020 IDLE: all strobes 0; run=1 -> ADDR next cycle.
REQ-021 ADDR: pc_oe=1, mem_rd=1; always -> WAIT.
REQ-022 WAIT: pc_oe=1, mem_rd=1; mem_rdy=1 -> LATCH, ir<=mem_data on that edge; else stay.
REQ-023 LATCH: pc_ini=1 exactly one cycle; ir_vld<=1; -> DISP.
REQ-024 DISP: ir_vld=1, ir stable; wait for dec_ack.
REQ-025 DISP, dec_ack=1, jmp=1: pc_ld<=jmp_addr, ir_vld<=0, -> LOAD.
REQ-026 DISP, dec_ack=1, jmp=0: ir_vld<=0; run=1 -> ADDR, run=0 -> IDLE.
REQ-027 LOAD: pc_lrc=1 one cycle with pc_ld stable; run=1 -> ADDR, run=0 -> IDLE.
REQ-028 run deasserted in ADDR/WAIT/LATCH SHALL NOT abort the fetch; sampled only in IDLE, DISP, LOAD.
REQ-029 Minimum fetch latency: ADDR to ir_vld=1 is 3 cycles with mem_rdy in first WAIT cycle.
REQ-030 pc_ini and pc_lrc SHALL never both be 1; pc_oe=0 whenever either is 1.
REQ-031 mem_rdy outside WAIT SHALL be ignored; jmp without dec_ack ignored.
REQ-032 dec_ack in the same cycle ir_vld rises (LATCH) SHALL be ignored.

Reset
REQ-033 rst=1 at any edge, any state: state<=IDLE; ir<=0, ir_vld<=0, pc_ld<=0, err<=0; all strobes 0 next cycle.
REQ-034 Reset mid-WAIT SHALL drop the fetch; no pc_ini issued.
REQ-035 rst has priority over every other input.

Configuration
REQ-036 Macro FETCH_CTRL_TIMEOUT_EN.
REQ-037 Defined: 4-bit wait counter cleared on entry to WAIT; 16th consecutive WAIT cycle without mem_rdy sets err=1 and -> IDLE, no pc_ini; err cleared only by rst.
REQ-038 Not defined: no counter; WAIT indefinite; err constant 0.

Verification
REQ-039 rst 2 cycles, run=1, mem_rdy=1 first WAIT cycle, mem_data=8'h3C -> is 0,1,2,3,4; ir=8'h3C, ir_vld=1 3 cycles after ADDR; one pc_ini pulse.
REQ-040 In DISP dec_ack=1, jmp=1, jmp_addr=16'h800A -> LOAD with pc_lrc=1, pc_ld=16'h800A one cycle, then ADDR.
REQ-041 mem_rdy held 0 for 5 WAIT cycles then 1 -> stays is=2 for 5 cycles, pc_oe/mem_rd high throughout, then LATCH.
REQ-042 run=0 asserted in WAIT, dec_ack in DISP -> fetch completes, returns IDLE, no further mem_rd.
REQ-043 rst=1 while in WAIT -> next cycle is=0, ir_vld=0, no pc_ini ever.
REQ-044 With FETCH_CTRL_TIMEOUT_EN, mem_rdy never asserted -> err=1 after 16 WAIT cycles, is=0; err=0 without macro.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer between memory, PC and decoder
//
// Purpose:
//   Sequences one instruction-byte fetch at a time: drives the PC onto the
//   address bus, waits for memory data, latches it into ir, bumps the PC,
//   presents the byte to the decoder and, on an acknowledged jump, reloads
//   the PC from the jump target.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous active-high reset, highest priority
//   run       in   1   level; keep fetching while high (sampled in IDLE/DISP/LOAD)
//   mem_rdy   in   1   memory read data valid (honoured only in WAIT)
//   mem_data  in   8   instruction byte from memory
//   dec_ack   in   1   decoder accepted the presented instruction (honoured only in DISP)
//   jmp       in   1   with dec_ack: redirect fetch to jmp_addr
//   jmp_addr  in  16   jump target
//   mem_rd    out  1   memory read strobe
//   pc_oe     out  1   drive PC onto the address bus
//   pc_ini    out  1   one-cycle PC increment pulse
//   pc_lrc    out  1   one-cycle PC load pulse
//   pc_ld     out 16   PC load value, valid while pc_lrc=1
//   ir        out  8   instruction register
//   ir_vld    out  1   ir holds an unconsumed instruction
//   is        out  3   current state encoding
//   err       out  1   sticky memory-timeout flag
//
// Configuration:
//   FETCH_CTRL_TIMEOUT_EN  when defined, a 4-bit counter abandons a fetch after
//                          16 consecutive WAIT cycles without mem_rdy and sets
//                          err (cleared only by rst). When undefined, WAIT is
//                          unbounded and err is constant 0.

module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_data,
    input  logic        dec_ack,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic        mem_rd,
    output logic        pc_oe,
    output logic        pc_ini,
    output logic        pc_lrc,
    output logic [15:0] pc_ld,
    output logic [7:0]  ir,
    output logic        ir_vld,
    output logic [2:0]  is,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        LATCH = 3'd3,
        DISP  = 3'd4,
        LOAD  = 3'd5
    } state_t;

    state_t state;
    state_t next;

    // High in the WAIT cycle that gives up on the memory; always 0 when the
    // timeout feature is not built.
    logic wait_expired;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes. Strobes are pure functions of the state, so
    // pc_ini (LATCH) and pc_lrc (LOAD) can never coincide with each other
    // or with pc_oe (ADDR/WAIT).
    // ------------------------------------------------------------------
    always_comb begin
        next   = state;
        mem_rd = 1'b0;
        pc_oe  = 1'b0;
        pc_ini = 1'b0;
        pc_lrc = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    next = ADDR;
                end
            end
            ADDR: begin
                mem_rd = 1'b1;
                pc_oe  = 1'b1;
                next   = WAIT;
            end
            WAIT: begin
                mem_rd = 1'b1;
                pc_oe  = 1'b1;
                if (mem_rdy) begin
                    next = LATCH;
                end else if (wait_expired) begin
                    next = IDLE;
                end
            end
            LATCH: begin
                // dec_ack is deliberately not looked at here: the decoder
                // cannot have seen this byte yet.
                pc_ini = 1'b1;
                next   = DISP;
            end
            DISP: begin
                if (dec_ack) begin
                    if (jmp) begin
                        next = LOAD;
                    end else if (run) begin
                        next = ADDR;
                    end else begin
                        next = IDLE;
                    end
                end
            end
            LOAD: begin
                pc_lrc = 1'b1;
                next   = run ? ADDR : IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction register, valid flag and PC load value
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ir     <= 8'h00;
            ir_vld <= 1'b0;
            pc_ld  <= 16'h0000;
        end else begin
            if ((state == WAIT) && mem_rdy) begin
                ir <= mem_data;
            end
            if (state == LATCH) begin
                ir_vld <= 1'b1;
            end
            if ((state == DISP) && dec_ack) begin
                ir_vld <= 1'b0;
                // pc_ld is held afterwards so it stays stable through LOAD.
                if (jmp) begin
                    pc_ld <= jmp_addr;
                end
            end
        end
    end

    assign is = state;

`ifdef FETCH_CTRL_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Memory timeout: wait_cnt counts WAIT cycles without mem_rdy. It is
    // cleared in ADDR, which is the only way into WAIT, so the first WAIT
    // cycle sees 0 and the 16th sees 15.
    // ------------------------------------------------------------------
    logic [3:0] wait_cnt;
    logic       err_q;

    assign wait_expired = (state == WAIT) && !mem_rdy && (wait_cnt == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'h0;
            err_q    <= 1'b0;
        end else begin
            if (state == ADDR) begin
                wait_cnt <= 4'h0;
            end else if ((state == WAIT) && !mem_rdy) begin
                wait_cnt <= wait_cnt + 4'h1;
            end
            if (wait_expired) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign wait_expired = 1'b0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with directed vectors

module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        mem_rdy;
    logic [7:0]  mem_data;
    logic        dec_ack;
    logic        jmp;
    logic [15:0] jmp_addr;
    logic        mem_rd;
    logic        pc_oe;
    logic        pc_ini;
    logic        pc_lrc;
    logic [15:0] pc_ld;
    logic [7:0]  ir;
    logic        ir_vld;
    logic [2:0]  is;
    logic        err;

    fetch_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mem_rdy  (mem_rdy),
        .mem_data (mem_data),
        .dec_ack  (dec_ack),
        .jmp      (jmp),
        .jmp_addr (jmp_addr),
        .mem_rd   (mem_rd),
        .pc_oe    (pc_oe),
        .pc_ini   (pc_ini),
        .pc_lrc   (pc_lrc),
        .pc_ld    (pc_ld),
        .ir       (ir),
        .ir_vld   (ir_vld),
        .is       (is),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe field order: {mem_rd, pc_oe, pc_ini, pc_lrc}
    localparam logic [3:0] N   = 4'b0000;
    localparam logic [3:0] RW  = 4'b1100;
    localparam logic [3:0] INI = 4'b0010;
    localparam logic [3:0] LRC = 4'b0001;

    typedef struct packed {
        logic [2:0]  is;
        logic [3:0]  stb;
        logic [7:0]  ir;
        logic        vld;
        logic [15:0] pcld;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_cyc  = 0;

    // Expected outputs for the cycle in which the inputs are applied.
    task automatic cyc(input logic r, input logic rdy, input logic [7:0] d,
                       input logic ack, input logic j, input logic [15:0] ja,
                       input logic rs,
                       input logic [2:0] e_is, input logic [3:0] e_stb,
                       input logic [7:0] e_ir, input logic e_vld,
                       input logic [15:0] e_pcld, input logic e_err);
        exp_t e;
        run      = r;
        mem_rdy  = rdy;
        mem_data = d;
        dec_ack  = ack;
        jmp      = j;
        jmp_addr = ja;
        rst      = rs;
        e.is   = e_is;
        e.stb  = e_stb;
        e.ir   = e_ir;
        e.vld  = e_vld;
        e.pcld = e_pcld;
        e.err  = e_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cyc++;
                n_cmp++;
                if (is !== e.is || {mem_rd, pc_oe, pc_ini, pc_lrc} !== e.stb ||
                    ir !== e.ir || ir_vld !== e.vld || pc_ld !== e.pcld || err !== e.err) begin
                    n_bad++;
                    $display("FAIL cyc%0d: got is=%0d stb=%b ir=%h vld=%b pc_ld=%h err=%b want is=%0d stb=%b ir=%h vld=%b pc_ld=%h err=%b",
                             n_cyc, is, {mem_rd, pc_oe, pc_ini, pc_lrc}, ir, ir_vld, pc_ld, err,
                             e.is, e.stb, e.ir, e.vld, e.pcld, e.err);
                end
                n_cmp++;
                if ((pc_ini && pc_lrc) || (pc_oe && (pc_ini || pc_lrc))) begin
                    n_bad++;
                    $display("FAIL strobe_excl cyc%0d: got pc_oe=%b pc_ini=%b pc_lrc=%b want exclusive",
                             n_cyc, pc_oe, pc_ini, pc_lrc);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; mem_data = 8'h00;
        dec_ack = 1'b0; jmp = 1'b0; jmp_addr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        // Basic fetch, 3C latched on first WAIT cycle; mem_rdy in ADDR ignored
        cyc(1, 0, 8'h00, 0, 0, 16'h0000, 0,  0, N,   8'h00, 0, 16'h0000, 0);
        cyc(1, 1, 8'hFF, 0, 0, 16'h0000, 0,  1, RW,  8'h00, 0, 16'h0000, 0);
        cyc(1, 1, 8'h3C, 0, 0, 16'h0000, 0,  2, RW,  8'h00, 0, 16'h0000, 0);
        // dec_ack+jmp during LATCH ignored
        cyc(1, 0, 8'h00, 1, 1, 16'h1234, 0,  3, INI, 8'h3C, 0, 16'h0000, 0);
        // jmp without dec_ack ignored
        cyc(1, 0, 8'h00, 0, 1, 16'h5555, 0,  4, N,   8'h3C, 1, 16'h0000, 0);
        // Jump to 800A
        cyc(1, 0, 8'h00, 1, 1, 16'h800A, 0,  4, N,   8'h3C, 1, 16'h0000, 0);
        cyc(1, 0, 8'h00, 0, 0, 16'h0000, 0,  5, LRC, 8'h3C, 0, 16'h800A, 0);
        cyc(1, 0, 8'h00, 0, 0, 16'h0000, 0,  1, RW,  8'h3C, 0, 16'h800A, 0);
        // Slow memory: 5 WAIT cycles without mem_rdy; run dropped mid-fetch
        cyc(1, 0, 8'h00, 0, 0, 16'h0000, 0,  2, RW,  8'h3C, 0, 16'h800A, 0);
        cyc(1, 0, 8'h00, 0, 0, 16'h0000, 0,  2, RW,  8'h3C, 0, 16'h800A, 0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  2, RW,  8'h3C, 0, 16'h800A, 0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  2, RW,  8'h3C, 0, 16'h800A, 0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  2, RW,  8'h3C, 0, 16'h800A, 0);
        cyc(0, 1, 8'hA5, 0, 0, 16'h0000, 0,  2, RW,  8'h3C, 0, 16'h800A, 0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  3, INI, 8'hA5, 0, 16'h800A, 0);
        cyc(0, 0, 8'h00, 1, 0, 16'h0000, 0,  4, N,   8'hA5, 1, 16'h800A, 0);
        // Back to IDLE, no further reads while run=0
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  0, N,   8'hA5, 0, 16'h800A, 0);
        cyc(1, 0, 8'h00, 0, 0, 16'h0000, 0,  0, N,   8'hA5, 0, 16'h800A, 0);
        cyc(1, 0, 8'h00, 0, 0, 16'h0000, 0,  1, RW,  8'hA5, 0, 16'h800A, 0);
        // Reset in WAIT wins over mem_rdy: fetch dropped, no pc_ini
        cyc(1, 1, 8'h77, 0, 0, 16'h0000, 1,  2, RW,  8'hA5, 0, 16'h800A, 0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  0, N,   8'h00, 0, 16'h0000, 0);
        // Memory never answers
        cyc(1, 0, 8'h00, 0, 0, 16'h0000, 0,  0, N,   8'h00, 0, 16'h0000, 0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  1, RW,  8'h00, 0, 16'h0000, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  2, RW,  8'h00, 0, 16'h0000, 0);
        end
`ifdef FETCH_CTRL_TIMEOUT_EN
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  0, N,   8'h00, 0, 16'h0000, 1);
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 1,  0, N,   8'h00, 0, 16'h0000, 1);
`else
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  2, RW,  8'h00, 0, 16'h0000, 0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 1,  2, RW,  8'h00, 0, 16'h0000, 0);
`endif
        cyc(0, 0, 8'h00, 0, 0, 16'h0000, 0,  0, N,   8'h00, 0, 16'h0000, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
